// File: rtl/sd_pkg.sv
// Shared types and constants for the SPI-mode SD data-block receiver.
package sd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_TOKEN,
        ST_DATA,
        ST_CRC,
        ST_DONE,
        ST_ERR
    } sd_state_e;

    localparam logic [7:0]  SD_DATA_TOKEN     = 8'hFE;
    localparam int          SD_BLOCK_BYTES    = 512;
    localparam logic [7:0]  SD_ERR_TOKEN_MASK = 8'hE0;
    localparam logic [15:0] SD_CRC16_POLY     = 16'h1021;

    // One MSB-first step of CRC16-CCITT.
    function automatic logic [15:0] sd_crc16_bit(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? SD_CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/sd_spi_byte_rx.sv
// MSB-first byte deserializer gated by the SCLK sample strobe.
module sd_spi_byte_rx (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       d_i,
    output logic [7:0] byte_o,
    output logic       byte_strobe_o
);

    logic [6:0] sh_q, sh_d;
    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            sh_d  = '0;
            cnt_d = '0;
        end else if (en_i) begin
            sh_d  = {sh_q[5:0], d_i};
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

    // The completed byte is presented combinationally on the 8th sample.
    assign byte_o        = {sh_q, d_i};
    assign byte_strobe_o = en_i && (cnt_q == 3'd7);

endmodule

// File: rtl/sd_block_rx.sv
// SD single-block read receiver: token hunt, 512 data bytes, CRC16 trailer.
// Define SD_BLOCK_RX_CRC_EN to check the trailer against a computed CRC16.
module sd_block_rx
    import sd_pkg::*;
#(
    parameter int TOKEN_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       bit_en,
    input  logic       D0,
    output logic       D1,
    output logic [7:0] byte_data,
    output logic [8:0] byte_addr,
    output logic       byte_valid,
    output logic       done,
    output logic       err_timeout,
    output logic       err_token,
    output logic       crc_err,
    output sd_state_e  state_dbg
);

    localparam int TW = $clog2(TOKEN_TIMEOUT + 1);

    sd_state_e   state_q, state_d;
    logic [8:0]  addr_q, addr_d;
    logic [TW-1:0] to_q, to_d, to_inc;
    logic [7:0]  data_q, data_d;
    logic [8:0]  baddr_q, baddr_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d, tmo_q, tmo_d, tok_q, tok_d;
    logic        rx_en, rx_clr, rx_strobe;
    logic [7:0]  rx_byte;
`ifdef SD_BLOCK_RX_CRC_EN
    logic [15:0] crc_q, crc_d;
    logic [7:0]  crc_hi_q, crc_hi_d;
    logic        crcerr_q, crcerr_d;
`endif

    assign rx_en  = bit_en && start &&
                    (state_q == ST_WAIT_TOKEN || state_q == ST_DATA || state_q == ST_CRC);
    assign rx_clr = (state_q == ST_IDLE);
    assign to_inc = (to_q == TW'(TOKEN_TIMEOUT)) ? to_q : to_q + TW'(1);

    sd_spi_byte_rx u_byte_rx (
        .clk_i        (clk),
        .rst_i        (reset),
        .clr_i        (rx_clr),
        .en_i         (rx_en),
        .d_i          (D0),
        .byte_o       (rx_byte),
        .byte_strobe_o(rx_strobe)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        to_d    = to_q;
        data_d  = data_q;
        baddr_d = baddr_q;
        valid_d = 1'b0;
        done_d  = done_q;
        tmo_d   = tmo_q;
        tok_d   = tok_q;
`ifdef SD_BLOCK_RX_CRC_EN
        crc_d    = crc_q;
        crc_hi_d = crc_hi_q;
        crcerr_d = crcerr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WAIT_TOKEN;
                    addr_d  = '0;
                    to_d    = '0;
                end
            end
            ST_WAIT_TOKEN: begin
                if (rx_strobe) begin
                    if (rx_byte == SD_DATA_TOKEN) begin
                        state_d = ST_DATA;
                        addr_d  = '0;
`ifdef SD_BLOCK_RX_CRC_EN
                        crc_d   = '0;
`endif
                    end else if ((rx_byte & SD_ERR_TOKEN_MASK) == 8'h00 && rx_byte != 8'h00) begin
                        tok_d   = 1'b1;
                        state_d = ST_ERR;
                    end else begin
                        to_d = to_inc;
                        if (to_inc == TW'(TOKEN_TIMEOUT)) begin
                            tmo_d   = 1'b1;
                            state_d = ST_ERR;
                        end
                    end
                end
            end
            ST_DATA: begin
`ifdef SD_BLOCK_RX_CRC_EN
                if (rx_en) crc_d = sd_crc16_bit(crc_q, D0);
`endif
                if (rx_strobe) begin
                    valid_d = 1'b1;
                    data_d  = rx_byte;
                    baddr_d = addr_q;
                    addr_d  = addr_q + 9'd1;
                    if (addr_q == 9'(SD_BLOCK_BYTES - 1)) state_d = ST_CRC;
                end
            end
            ST_CRC: begin
                // addr_q wrapped to 0 entering this state and now indexes the trailer byte.
                if (rx_strobe) begin
                    addr_d = addr_q + 9'd1;
                    if (addr_q[0]) begin
`ifdef SD_BLOCK_RX_CRC_EN
                        if ({crc_hi_q, rx_byte} != crc_q) begin
                            crcerr_d = 1'b1;
                            state_d  = ST_ERR;
                        end else begin
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end
`else
                        done_d  = 1'b1;
                        state_d = ST_DONE;
`endif
                    end else begin
`ifdef SD_BLOCK_RX_CRC_EN
                        crc_hi_d = rx_byte;
`endif
                    end
                end
            end
            default: ;
        endcase
        if (!start) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            done_d  = 1'b0;
            tmo_d   = 1'b0;
            tok_d   = 1'b0;
`ifdef SD_BLOCK_RX_CRC_EN
            crcerr_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            to_q    <= '0;
            data_q  <= '0;
            baddr_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
            tok_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            to_q    <= to_d;
            data_q  <= data_d;
            baddr_q <= baddr_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
            tok_q   <= tok_d;
        end
    end

`ifdef SD_BLOCK_RX_CRC_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_q    <= '0;
            crc_hi_q <= '0;
            crcerr_q <= 1'b0;
        end else begin
            crc_q    <= crc_d;
            crc_hi_q <= crc_hi_d;
            crcerr_q <= crcerr_d;
        end
    end
    assign crc_err = crcerr_q;
`else
    assign crc_err = 1'b0;
`endif

    // byte_valid is a one-cycle pulse with no back-pressure; byte_data/byte_addr hold until the next pulse.
    assign D1          = 1'b1;
    assign byte_data   = data_q;
    assign byte_addr   = baddr_q;
    assign byte_valid  = valid_q;
    assign done        = done_q;
    assign err_timeout = tmo_q;
    assign err_token   = tok_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_sd_block_rx.sv
// Directed bench for sd_block_rx with a stream-level reference model and scoreboard.
module tb_sd_block_rx;
    import sd_pkg::*;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       reset, start, bit_en, D0;
    logic       D1, byte_valid, done, err_timeout, err_token, crc_err;
    logic [7:0] byte_data;
    logic [8:0] byte_addr;
    sd_state_e  state_dbg;

    sd_block_rx #(.TOKEN_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .bit_en(bit_en), .D0(D0),
        .D1(D1), .byte_data(byte_data), .byte_addr(byte_addr), .byte_valid(byte_valid),
        .done(done), .err_timeout(err_timeout), .err_token(err_token), .crc_err(crc_err),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_checks = 0;
    logic [16:0] exp_q[$];
    logic [7:0]  stim_q[$];
    logic exp_done = 1'b0, exp_tmo = 1'b0, exp_tok = 1'b0, exp_crc = 1'b0;
    logic pend_done, pend_tmo, pend_tok, pend_crc;
    int   decide_idx;
    int   pulse_total = 0;
    logic [8:0] last_addr = '0;
    logic [7:0] last_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    // Three fill bytes, the data token, bytes 0x00..0xFF twice, then the CRC trailer.
    task automatic build_block(input logic [15:0] flip);
        logic [15:0] c;
        logic [7:0]  b;
        stim_q.delete();
        for (int i = 0; i < 3; i++) stim_q.push_back(8'hFF);
        stim_q.push_back(8'hFE);
        c = '0;
        for (int i = 0; i < 512; i++) begin
            b = 8'(i);
            stim_q.push_back(b);
            c = crc16_byte(c, b);
        end
        c = c ^ flip;
        stim_q.push_back(c[15:8]);
        stim_q.push_back(c[7:0]);
    endtask

    // Walk the byte stream by the protocol rules and predict pulses and the final flags.
    task automatic model_run();
        int ph, to, addr, nc;
        logic [15:0] c, rx;
        logic [7:0]  b;
        ph = 0; to = 0; addr = 0; nc = 0; c = '0; rx = '0;
        pend_done = 0; pend_tmo = 0; pend_tok = 0; pend_crc = 0;
        decide_idx = -1;
        for (int i = 0; i < stim_q.size(); i++) begin
            b = stim_q[i];
            if (ph == 0) begin
                if (b == 8'hFE) ph = 1;
                else if (b < 8'h20 && b != 8'h00) begin pend_tok = 1; decide_idx = i; break; end
                else begin
                    to++;
                    if (to == TMO) begin pend_tmo = 1; decide_idx = i; break; end
                end
            end else if (ph == 1) begin
                exp_q.push_back({9'(addr), b});
                c = crc16_byte(c, b);
                addr++;
                if (addr == 512) ph = 2;
            end else begin
                rx = {rx[7:0], b};
                nc++;
                if (nc == 2) begin
                    decide_idx = i;
`ifdef SD_BLOCK_RX_CRC_EN
                    if (rx != c) pend_crc = 1; else pend_done = 1;
`else
                    pend_done = 1;
`endif
                    break;
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic apply);
        for (int k = 7; k >= 0; k--) begin
            @(negedge clk);
            D0 = b[k];
            bit_en = 1'b1;
            if (k == 0 && apply) begin
                exp_done = pend_done; exp_tmo = pend_tmo; exp_tok = pend_tok; exp_crc = pend_crc;
            end
            @(negedge clk);
            bit_en = 1'b0;
        end
        D0 = 1'b1;
    endtask

    task automatic drive(input int from, input int upto);
        for (int i = from; i < upto; i++) send_byte(stim_q[i], i == decide_idx);
    endtask

    task automatic start_block();
        @(negedge clk);
        start = 1'b1;
    endtask

    task automatic end_block();
        @(negedge clk);
        start = 1'b0;
        exp_done = 0; exp_tmo = 0; exp_tok = 0; exp_crc = 0;
        repeat (2) @(negedge clk);
        check("idle_after_release", 32'(state_dbg), 32'(ST_IDLE));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_D1"}, 32'(D1), 32'd1);
        check({tag, "_byte_data"}, 32'(byte_data), 32'd0);
        check({tag, "_byte_addr"}, 32'(byte_addr), 32'd0);
        check({tag, "_byte_valid"}, 32'(byte_valid), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
        check({tag, "_err_token"}, 32'(err_token), 32'd0);
        check({tag, "_crc_err"}, 32'(crc_err), 32'd0);
        check({tag, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
    endtask

    // Scoreboard: every pulse must match the queue head; flags must match the model every cycle.
    always @(posedge clk) begin
        logic [16:0] e;
        #2;
        check("D1_const", 32'(D1), 32'd1);
        if (byte_valid === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_byte_valid", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                check("byte_addr", 32'(byte_addr), 32'(e[16:8]));
                check("byte_data", 32'(byte_data), 32'(e[7:0]));
            end
            pulse_total++;
            last_addr = byte_addr;
            last_data = byte_data;
        end
        check("done", 32'(done), 32'(exp_done));
        check("err_timeout", 32'(err_timeout), 32'(exp_tmo));
        check("err_token", 32'(err_token), 32'(exp_tok));
        check("crc_err", 32'(crc_err), 32'(exp_crc));
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string s;
        logic [15:0] c;
        int base;
        reset = 1'b1; start = 1'b0; bit_en = 1'b0; D0 = 1'b1;

        s = "123456789";
        c = '0;
        for (int i = 0; i < s.len(); i++) c = crc16_byte(c, s[i]);
        check("model_crc16_check", 32'(c), 32'h31C3);

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
        @(negedge clk);

        // Happy path
        build_block(16'h0000);
        model_run();
        base = pulse_total;
        start_block();
        drive(0, stim_q.size());
        @(negedge clk);
        check("happy_pulses", 32'(pulse_total - base), 32'd512);
        check("happy_last_addr", 32'(last_addr), 32'd511);
        check("happy_last_data", 32'(last_data), 32'hFF);
        check("happy_done", 32'(done), 32'd1);
        check("happy_state", 32'(state_dbg), 32'(ST_DONE));
        check("happy_queue_empty", 32'(exp_q.size()), 32'd0);
        end_block();

        // Error token
        stim_q.delete();
        stim_q.push_back(8'hFF); stim_q.push_back(8'hFF); stim_q.push_back(8'h09);
        model_run();
        base = pulse_total;
        start_block();
        drive(0, stim_q.size());
        check("tok_err_token", 32'(err_token), 32'd1);
        check("tok_done", 32'(done), 32'd0);
        check("tok_state", 32'(state_dbg), 32'(ST_ERR));
        check("tok_pulses", 32'(pulse_total - base), 32'd0);
        end_block();

        // Timeout after exactly TMO fill bytes
        stim_q.delete();
        for (int i = 0; i < TMO; i++) stim_q.push_back(8'hFF);
        model_run();
        start_block();
        drive(0, TMO - 1);
        check("tmo_not_yet", 32'(err_timeout), 32'd0);
        drive(TMO - 1, TMO);
        check("tmo_err_timeout", 32'(err_timeout), 32'd1);
        check("tmo_state", 32'(state_dbg), 32'(ST_ERR));
        end_block();

        // Corrupted CRC trailer
        build_block(16'h0001);
        model_run();
        base = pulse_total;
        start_block();
        drive(0, stim_q.size());
        @(negedge clk);
        check("crcflip_pulses", 32'(pulse_total - base), 32'd512);
`ifdef SD_BLOCK_RX_CRC_EN
        check("crcflip_crc_err", 32'(crc_err), 32'd1);
        check("crcflip_done", 32'(done), 32'd0);
`else
        check("crcflip_crc_err", 32'(crc_err), 32'd0);
        check("crcflip_done", 32'(done), 32'd1);
`endif
        end_block();

        // Abort after data byte 100, then a fresh block
        build_block(16'h0000);
        model_run();
        start_block();
        drive(0, 4 + 101);
        check("abort_last_addr", 32'(last_addr), 32'd100);
        @(negedge clk);
        start = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("abort_idle", 32'(state_dbg), 32'(ST_IDLE));
        base = pulse_total;
        drive(105, 125);
        check("abort_no_pulses", 32'(pulse_total - base), 32'd0);
        model_run();
        base = pulse_total;
        start_block();
        drive(0, 5);
        check("restart_addr0", 32'(byte_addr), 32'd0);
        drive(5, stim_q.size());
        @(negedge clk);
        check("restart_pulses", 32'(pulse_total - base), 32'd512);
        check("restart_done", 32'(done), 32'd1);
        end_block();

        // Reset during data byte 300, then a full block
        model_run();
        start_block();
        drive(0, 4 + 301);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        exp_q.delete();
        #1;
        check_reset_values("midreset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_run();
        base = pulse_total;
        start_block();
        drive(0, stim_q.size());
        @(negedge clk);
        check("postreset_pulses", 32'(pulse_total - base), 32'd512);
        check("postreset_last_addr", 32'(last_addr), 32'd511);
        check("postreset_done", 32'(done), 32'd1);
        end_block();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
